// File: rtl/periph_pkg.sv
// ----------------------------------------------------------------------------
// periph_pkg
// Shared definitions for the peripheral receive path.
//   periph_state_e : handshake FSM states (SYNC, IDLE, ACK)
//   PERIPH_DATA_W  : default sender word width
//   PERIPH_DEPTH   : default FIFO depth in words (power of two, >= 2)
//   periph_cnt_w   : width of a 0..depth occupancy counter
// ----------------------------------------------------------------------------
package periph_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    ACK  = 2'd2
  } periph_state_e;

  localparam int PERIPH_DATA_W = 16;
  localparam int PERIPH_DEPTH  = 4;

  // Bits needed to hold an occupancy value from 0 up to and including depth.
  function automatic int periph_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/periph_fifo.sv
// ----------------------------------------------------------------------------
// periph_fifo
// First-word-fall-through FIFO with registered head, count and flags.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   wr_en    in   write request (ignored when full without a same-edge pop)
//   wr_data  in   DATA_W word to write
//   rd_en    in   pop request (ignored while empty)
//   rd_data  out  head-of-FIFO word, 0 while empty
//   empty    out  no words stored
//   full     out  DEPTH words stored
//   count    out  number of stored words
// ----------------------------------------------------------------------------
module periph_fifo
  import periph_pkg::*;
#(
  parameter int DATA_W = PERIPH_DATA_W,
  parameter int DEPTH  = PERIPH_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = periph_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_n_s, wr_ptr_n_s;
  logic [CNT_W-1:0]  count_r, count_n_s;
  logic [DATA_W-1:0] rd_data_r, head_n_s;
  logic              empty_r, full_r;
  logic              pop_s, wr_s;

  // Qualified pop/write, next pointers, next count and next head word.
  always_comb begin
    pop_s      = rd_en && !empty_r;
    // A pop on the same edge frees a slot, so a full FIFO still takes a write.
    wr_s       = wr_en && ((count_r != FULL_CNT) || pop_s);
    rd_ptr_n_s = rd_ptr_r;
    wr_ptr_n_s = wr_ptr_r;
    count_n_s  = count_r;
    head_n_s   = {DATA_W{1'b0}};

    if (pop_s) begin
      rd_ptr_n_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_n_s = rd_ptr_r;
    end

    if (wr_s) begin
      wr_ptr_n_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_n_s = wr_ptr_r;
    end

    case ({wr_s, pop_s})
      2'b10:   count_n_s = count_r + ONE_CNT;
      2'b01:   count_n_s = count_r - ONE_CNT;
      default: count_n_s = count_r;
    endcase

    // The word being written becomes the head only when it will be the sole
    // occupant; otherwise the head is already in storage.
    if (count_n_s == ZERO_CNT) begin
      head_n_s = {DATA_W{1'b0}};
    end else if (wr_s && (count_n_s == ONE_CNT)) begin
      head_n_s = wr_data;
    end else begin
      head_n_s = mem_r[rd_ptr_n_s];
    end
  end

  // Storage, pointers, count and registered FWFT outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      rd_ptr_r  <= {PTR_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= ZERO_CNT;
      rd_data_r <= {DATA_W{1'b0}};
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= wr_data;
      end
      rd_ptr_r  <= rd_ptr_n_s;
      wr_ptr_r  <= wr_ptr_n_s;
      count_r   <= count_n_s;
      rd_data_r <= head_n_s;
      empty_r   <= (count_n_s == ZERO_CNT);
      full_r    <= (count_n_s == FULL_CNT);
    end
  end

  assign rd_data = rd_data_r;
  assign empty   = empty_r;
  assign full    = full_r;
  assign count   = count_r;

endmodule

// File: rtl/peripheral_rx_fifo.sv
// ----------------------------------------------------------------------------
// peripheral_rx_fifo
// Four-phase send/ack receiver feeding a FWFT FIFO. Full FIFO back-pressures
// the sender by withholding outack. After reset the block waits for send=0
// before accepting, so a request held across reset is not captured twice.
// Optional feature macro: PERIPH_STATS_EN adds the 16-bit xfer_cnt output
// counting accepted words (wraps at 0xFFFF).
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   send     in   sender request
//   dataP    in   sender data word
//   outack   out  registered acknowledge to sender
//   rd_en    in   consumer pop
//   rd_data  out  head-of-FIFO word, 0 while empty
//   empty    out  FIFO empty
//   full     out  FIFO full
//   count    out  stored words
//   xfer_cnt out  accepted-transfer counter (PERIPH_STATS_EN only)
// ----------------------------------------------------------------------------
module peripheral_rx_fifo
  import periph_pkg::*;
#(
  parameter int DATA_W = PERIPH_DATA_W,
  parameter int DEPTH  = PERIPH_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         send,
  input  logic [DATA_W-1:0]            dataP,
  output logic                         outack,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PERIPH_STATS_EN
  ,
  output logic [15:0]                  xfer_cnt
`endif
);

  localparam int CNT_W = periph_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  periph_state_e state_r, state_n_s;
  logic          outack_r;
  logic          wr_s;
  logic          accept_s;
  logic          fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;

  assign accept_s = (fifo_count_s != FULL_CNT) || (rd_en && !fifo_empty_s);

  // Handshake next-state and write strobe.
  always_comb begin
    state_n_s = state_r;
    wr_s      = 1'b0;
    case (state_r)
      SYNC: begin
        if (!send) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = SYNC;
        end
      end
      IDLE: begin
        if (send && accept_s) begin
          wr_s      = 1'b1;
          state_n_s = ACK;
        end else begin
          state_n_s = IDLE;
        end
      end
      ACK: begin
        if (!send) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = ACK;
        end
      end
      default: begin
        state_n_s = SYNC;
      end
    endcase
  end

  // State register and registered acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= SYNC;
      outack_r <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      outack_r <= (state_n_s == ACK);
    end
  end

  assign outack = outack_r;

  periph_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_s),
    .wr_data (dataP),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty_s),
    .full    (full),
    .count   (fifo_count_s)
  );

  assign empty = fifo_empty_s;
  assign count = fifo_count_s;

`ifdef PERIPH_STATS_EN
  logic [15:0] xfer_cnt_r;

  // Accepted-word counter; natural 16-bit wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt_r <= 16'h0000;
    end else if (wr_s) begin
      xfer_cnt_r <= xfer_cnt_r + 16'h0001;
    end else begin
      xfer_cnt_r <= xfer_cnt_r;
    end
  end

  assign xfer_cnt = xfer_cnt_r;
`endif

endmodule

// File: tb/tb_peripheral_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_peripheral_rx_fifo
// Table-driven directed vectors, a reset-mid-transfer sequence and a random
// sender/consumer run checked against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_peripheral_rx_fifo;

  localparam int DW = 16;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          send;
  logic [DW-1:0] dataP;
  logic          outack;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
`ifdef PERIPH_STATS_EN
  logic [15:0]   xfer_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int n_acc = 0;

  always #5 clk = ~clk;

  peripheral_rx_fifo #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk     (clk),
    .rst     (rst),
    .send    (send),
    .dataP   (dataP),
    .outack  (outack),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
`ifdef PERIPH_STATS_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );

  typedef struct {
    logic          snd;
    logic [DW-1:0] d;
    logic          rd;
    logic          ack;
    logic [CW-1:0] cnt;
    logic          ful;
    logic [DW-1:0] rdd;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic a, input int c, input logic [DW-1:0] r);
    chk({tag, ".outack"},  32'(outack),  32'(a));
    chk({tag, ".count"},   32'(count),   32'(c));
    chk({tag, ".empty"},   32'(empty),   32'(c == 0));
    chk({tag, ".full"},    32'(full),    32'(c == DP));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(r));
  endtask

  // reference model state for the random run
  logic [DW-1:0] q [$];
  logic          m_ack;
  int            st;
  logic [DW-1:0] seq;
  logic          pop, acc, cap;

  initial begin
    tbl[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 3'd1, 1'b0, 16'h1234};
    tbl[2]  = '{1'b0, 16'h1234, 1'b0, 1'b0, 3'd1, 1'b0, 16'h1234};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000};
    tbl[4]  = '{1'b1, 16'h00A0, 1'b0, 1'b1, 3'd1, 1'b0, 16'h00A0};
    tbl[5]  = '{1'b0, 16'h00A0, 1'b0, 1'b0, 3'd1, 1'b0, 16'h00A0};
    tbl[6]  = '{1'b1, 16'h00A1, 1'b0, 1'b1, 3'd2, 1'b0, 16'h00A0};
    tbl[7]  = '{1'b0, 16'h00A1, 1'b0, 1'b0, 3'd2, 1'b0, 16'h00A0};
    tbl[8]  = '{1'b1, 16'h00A2, 1'b0, 1'b1, 3'd3, 1'b0, 16'h00A0};
    tbl[9]  = '{1'b0, 16'h00A2, 1'b0, 1'b0, 3'd3, 1'b0, 16'h00A0};
    tbl[10] = '{1'b1, 16'h00A3, 1'b0, 1'b1, 3'd4, 1'b1, 16'h00A0};
    tbl[11] = '{1'b0, 16'h00A3, 1'b0, 1'b0, 3'd4, 1'b1, 16'h00A0};
    tbl[12] = '{1'b1, 16'h00A4, 1'b0, 1'b0, 3'd4, 1'b1, 16'h00A0};
    tbl[13] = '{1'b1, 16'h00A4, 1'b0, 1'b0, 3'd4, 1'b1, 16'h00A0};
    tbl[14] = '{1'b1, 16'h00A4, 1'b1, 1'b1, 3'd4, 1'b1, 16'h00A1};
    tbl[15] = '{1'b0, 16'h00A4, 1'b0, 1'b0, 3'd4, 1'b1, 16'h00A1};
    tbl[16] = '{1'b0, 16'h00A4, 1'b1, 1'b0, 3'd3, 1'b0, 16'h00A2};
    tbl[17] = '{1'b0, 16'h00A4, 1'b1, 1'b0, 3'd2, 1'b0, 16'h00A3};
    tbl[18] = '{1'b0, 16'h00A4, 1'b1, 1'b0, 3'd1, 1'b0, 16'h00A4};
    tbl[19] = '{1'b0, 16'h00A4, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000};
    tbl[20] = '{1'b0, 16'h00A4, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000};
    tbl[21] = '{1'b1, 16'h0BEE, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0BEE};
    tbl[22] = '{1'b0, 16'h0BEE, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000};

    // reset state
    rst = 1'b0; send = 1'b0; rd_en = 1'b0; dataP = 16'h0000;
    #12;
    chk_all("reset", 1'b0, 0, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // directed table: single transfer, fill/stall, pop-accept, empty pop
    for (int i = 0; i < 23; i++) begin
      send  = tbl[i].snd;
      dataP = tbl[i].d;
      rd_en = tbl[i].rd;
      tick();
      chk($sformatf("vec%0d.outack", i),  32'(outack),  32'(tbl[i].ack));
      chk($sformatf("vec%0d.count", i),   32'(count),   32'(tbl[i].cnt));
      chk($sformatf("vec%0d.empty", i),   32'(empty),   32'(tbl[i].cnt == 3'd0));
      chk($sformatf("vec%0d.full", i),    32'(full),    32'(tbl[i].ful));
      chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].rdd));
    end

    // reset asserted while in ACK with send held high
    send = 1'b1; dataP = 16'h7777; rd_en = 1'b0;
    tick();
    chk_all("pre_rst", 1'b1, 1, 16'h7777);
    #2;
    rst = 1'b0;
    #1;
    chk_all("mid_rst", 1'b0, 0, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(); tick(); tick();
    chk_all("sync_hold", 1'b0, 0, 16'h0000);
    send = 1'b0;
    tick();
    chk_all("sync_drop", 1'b0, 0, 16'h0000);
    send = 1'b1; dataP = 16'h55AA;
    tick();
    chk_all("recap", 1'b1, 1, 16'h55AA);
    send = 1'b0;
    tick();
    chk_all("recap_rel", 1'b0, 1, 16'h55AA);
    tick(); tick();
    chk_all("recap_once", 1'b0, 1, 16'h55AA);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk_all("recap_pop", 1'b0, 0, 16'h0000);
    n_acc = 1;

    // random sender/consumer against queue model
    q.delete();
    m_ack = 1'b0;
    st    = 0;
    seq   = 16'h0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd.outack",  32'(outack),  32'(m_ack));
      chk("rnd.count",   32'(count),   32'(q.size()));
      chk("rnd.empty",   32'(empty),   32'(q.size() == 0));
      chk("rnd.full",    32'(full),    32'(q.size() == DP));
      chk("rnd.rd_data", 32'(rd_data), (q.size() > 0) ? 32'(q[0]) : 32'd0);

      // sender: request -> see ack -> release -> see ack drop -> idle
      if (st == 2 && !m_ack) st = 0;
      if (st == 0) begin
        if ($urandom_range(0, 3) != 0) begin
          st    = 1;
          dataP = seq;
          seq   = seq + 16'h0001;
        end
      end else if (st == 1 && m_ack) begin
        if ($urandom_range(0, 2) != 0) st = 2;
      end
      send  = (st == 1);
      rd_en = (cyc < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);

      pop = rd_en && (q.size() > 0);
      acc = (q.size() < DP) || pop;
      cap = send && !m_ack && acc;
      if (pop) void'(q.pop_front());
      if (cap) begin
        q.push_back(dataP);
        n_acc++;
        m_ack = 1'b1;
      end else if (!send) begin
        m_ack = 1'b0;
      end
      tick();
    end
    send = 1'b0; rd_en = 1'b0;

`ifdef PERIPH_STATS_EN
    chk("stats.after_rnd", 32'(xfer_cnt), 32'(n_acc[15:0]));
    rst = 1'b0;
    tick();
    rst   = 1'b1;
    rd_en = 1'b1;
    tick();
    for (int i = 0; i < 32'h10001; i++) begin
      send  = 1'b1;
      dataP = i[15:0];
      tick();
      send = 1'b0;
      tick();
    end
    rd_en = 1'b0;
    chk("stats.wrap", 32'(xfer_cnt), 32'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/peripheral_rx_fifo.md
# peripheral_rx_fifo

Parametrised peripheral receiver: accepts words from a sender over a four-phase send/ack handshake and buffers them in an internal FIFO. A downstream consumer reads them through a first-word-fall-through read port. It replaces the fixed 16-bit, unbuffered peripheral acknowledger. It adds configurable width and depth, back-pressure when full, and safe recovery from reset mid-transfer.

## Interface
- DATA_W, 16, width of the sender data word
- DEPTH, 4, FIFO depth in words; power of two, ≥ 2
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- send  in  1  sender request; held high until outack seen, then dropped
- dataP  in  DATA_W  sender data; stable while send=1 and outack=0
- outack  out  1  registered acknowledge to sender
- rd_en  in  1  consumer pop request
- rd_data  out  DATA_W  head-of-FIFO word (FWFT); 0 while empty
- empty  out  1  FIFO holds no words
- full  out  1  FIFO holds DEPTH words
- count  out  $clog2(DEPTH+1)  number of stored words
- xfer_cnt  out  16  accepted-transfer counter (only with PERIPH_STATS_EN)

## Operation
- Reset (rst=0, asynchronous): state SYNC, outack=0, FIFO pointers/count=0, empty=1, full=0, rd_data=0, xfer_cnt=0.
- States:
  - SYNC: outack=0, waits for send=0, then goes to IDLE. Prevents a request already high at reset release from being captured twice.
  - IDLE: outack=0. If send=1 and accept is true, write dataP into the FIFO and go to ACK. Otherwise stay in IDLE; this is the stall.
  - ACK: outack=1. Stay while send=1. When send=0, go to IDLE.
- accept = (count < DEPTH) or (rd_en and not empty). A pop on the same edge frees the slot, so a full FIFO with a simultaneous pop still accepts.
- Pop: rd_en=1 and empty=0 advances the read pointer. rd_en while empty is ignored, with no underflow and no count change.
- Simultaneous write and pop: count unchanged; both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full and empty are derived from count.
- No data is dropped. A full FIFO holds off the sender by withholding outack.

## Timing
- A write decided at edge N is visible after edge N: outack=1, count+1, empty=0. If the FIFO was empty, rd_data shows the new word after edge N.
- send=0 sampled at edge M in ACK gives outack=0 after edge M. The earliest next capture is edge M+1.
- Minimum handshake period: 2 cycles per word (IDLE→ACK→IDLE) with a sender that reacts in 0 cycles. Throughput is at most 1 word per 2 cycles.
- Pop at edge K: the next word, or 0 if the FIFO becomes empty, appears on rd_data after edge K.
- Reset asserted mid-transfer: outack drops immediately (asynchronous). After release the block stays in SYNC until the sender drops send.

## Configuration
- PERIPH_STATS_EN defined:
  - xfer_cnt port exists.
  - It increments by 1 on every accepted write and wraps from 0xFFFF to 0.
  - It is cleared by reset.
- PERIPH_STATS_EN undefined: no xfer_cnt port or counter logic. All other behaviour is identical.

## Structure
- Shared package periph_pkg:
  - state enum periph_state_e {SYNC, IDLE, ACK}
  - default constants PERIPH_DATA_W=16 and PERIPH_DEPTH=4
- One sub-module, periph_fifo:
  - parametrised storage, pointers and count
  - FWFT read
  - write/pop ports
- The top level holds the handshake FSM and the optional statistics counter.

## Test plan
- Single transfer: after reset, send=1 with dataP=0x1234. Expect outack=1 one edge later, and rd_data=0x1234, count=1, empty=0. Then send=0; expect outack=0 one edge later.
- Fill and stall (DEPTH=4): four transfers of 0xA0..0xA3, then a fifth of 0xA4. Expect full=1 and outack to stay 0 while 0xA4 is held. A pop of 0xA0 with rd_en gives outack=1 on the same edge accept, count stays 4, and the next rd_data=0xA1.
- Wrap-around: 10 transfers interleaved with pops. Expect read order 0..9 exactly and count never above 4.
- Empty pop: rd_en=1 while empty. Expect count=0, rd_data=0, empty=1 unchanged.
- Reset mid-transfer: rst=0 while in ACK with send=1. Expect outack=0 immediately and the FIFO cleared. After release with send still 1, expect no capture. Then send=0 and send=1 with 0x55AA; expect a single capture of 0x55AA.
- PERIPH_STATS_EN defined: 0x10001 accepted transfers. Expect xfer_cnt=0x0001 after the wrap.
